// File: rtl/perceptron_uart_node.sv
// Two-input perceptron (16-bit signed weights/inputs, step output)
// reached over an 8N1 UART byte command protocol.
module perceptron_uart_node #(
   parameter int CLOCK_FREQUENCY = 12000000,
   parameter int BAUD_RATE       = 9600,
   parameter int TIMEOUT_BYTES   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic tx
);
   localparam int BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int TO  = TIMEOUT_BYTES * 10 * BIT;
   localparam int CW  = $clog2(BIT + 1);
   localparam int TW  = $clog2(TO + 1);

   localparam logic [7:0] OP_READ = 8'd5;
   localparam logic [7:0] OP_WW   = 8'd50;
   localparam logic [7:0] OP_WI   = 8'd51;
   localparam logic [7:0] OP_RESP = 8'd100;
   localparam logic [7:0] OP_OK   = 8'd101;
   localparam logic [7:0] OP_ERR  = 8'd102;

   typedef enum logic [1:0] {IDLE, COLLECT, RESPOND} state_t;
   typedef enum logic [1:0] {K_READ, K_ACK, K_ERR} kind_t;

   // async assert, release synchronised to clk
   logic [1:0] rst_sync;
   logic       rst_i;
   always_ff @(posedge clk or posedge rst)
      if (rst) rst_sync <= 2'b11;
      else     rst_sync <= {rst_sync[0], 1'b0};
   assign rst_i = rst_sync[1];

   logic [2:0]    rx_sync;
   logic          rx_s;
   logic          rx_p;
   logic          rx_busy;
   logic [CW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_data;
   logic          rx_valid;

   assign rx_s = rx_sync[1];
   assign rx_p = rx_sync[2];

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) rx_sync <= 3'b111;
      else       rx_sync <= {rx_sync[1:0], rx};

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         rx_busy  <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_p && !rx_s) begin
               rx_busy <= 1'b1;
               rx_cnt  <= CW'(BIT / 2 - 1);
               rx_bit  <= '0;
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
         end else begin
            rx_cnt <= CW'(BIT - 1);
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               if (rx_s) rx_busy <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_busy  <= 1'b0;
               rx_valid <= rx_s;
            end else begin
               rx_data <= {rx_s, rx_data[7:1]};
            end
         end
      end

   logic          tx_busy;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_shift;
   logic          tx_start;
   logic [7:0]    tx_byte;
   logic          tx_ready;

   // ready in the last stop-bit clock so response bytes run back-to-back
   assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == '0);

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '1;
      end else if (tx_start) begin
         tx       <= 1'b0;
         tx_shift <= {1'b1, tx_byte};
         tx_cnt   <= CW'(BIT - 1);
         tx_bit   <= '0;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
         end else if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_cnt   <= CW'(BIT - 1);
            tx_bit   <= tx_bit + 4'd1;
         end
      end

   logic signed [15:0] w1, w2, x1, x2;
   logic signed [31:0] p1, p2;
   logic [32:0]        sum;
   logic [15:0]        result;

   assign p1  = w1 * x1;
   assign p2  = w2 * x2;
   assign sum = {p1[31], p1} + {p2[31], p2};

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) result <= 16'h0001;
      else       result <= {15'd0, ~sum[32]};

   state_t        state, state_n;
   kind_t         kind;
   logic [2:0]    idx, len;
   logic [1:0]    pcnt;
   logic          tgt_w;
   logic [23:0]   pay;
   logic [TW-1:0] tmr;
   logic          commit;
   logic [7:0]    read_byte;

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) state <= IDLE;
      else       state <= state_n;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (rx_valid)
               state_n = (rx_data == OP_WW || rx_data == OP_WI) ?
                         COLLECT : RESPOND;
         COLLECT:
            if (rx_valid) begin
               if (pcnt == 2'd3) state_n = RESPOND;
            end else if (tmr == TW'(TO)) begin
               state_n = IDLE;
            end
         RESPOND:
            if (idx == len && !tx_busy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      unique case (idx)
         3'd0:    read_byte = OP_RESP;
         3'd1:    read_byte = w1[15:8];
         3'd2:    read_byte = w1[7:0];
         3'd3:    read_byte = w2[15:8];
         3'd4:    read_byte = w2[7:0];
         3'd5:    read_byte = result[15:8];
         default: read_byte = result[7:0];
      endcase
   end

   always_comb begin
      tx_start = 1'b0;
      commit   = 1'b0;
      tx_byte  = OP_ERR;
      unique case (state)
         COLLECT: commit   = rx_valid && pcnt == 2'd3;
         RESPOND: tx_start = tx_ready && idx != len;
         default: ;
      endcase
      unique case (1'b1)
         kind == K_ACK:  tx_byte = OP_OK;
         kind == K_READ: tx_byte = read_byte;
         default:        tx_byte = OP_ERR;
      endcase
   end

   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         kind  <= K_ERR;
         idx   <= '0;
         len   <= '0;
         pcnt  <= '0;
         tgt_w <= 1'b0;
         pay   <= '0;
         tmr   <= '0;
         w1    <= '0;
         w2    <= '0;
         x1    <= '0;
         x2    <= '0;
      end else begin
         if (tx_start) idx <= idx + 3'd1;
         if (state == IDLE && rx_valid) begin
            idx   <= '0;
            pcnt  <= '0;
            tmr   <= '0;
            tgt_w <= rx_data == OP_WW;
            kind  <= (rx_data == OP_READ) ? K_READ : K_ERR;
            len   <= (rx_data == OP_READ) ? 3'd7 : 3'd1;
         end
         if (state == COLLECT) begin
            tmr <= rx_valid ? '0 : tmr + 1'b1;
            if (rx_valid) begin
               pcnt <= pcnt + 2'd1;
               pay  <= {pay[15:0], rx_data};
            end
         end
         // all four halves land in one clock
         if (commit) begin
            kind <= K_ACK;
            len  <= 3'd1;
            idx  <= '0;
            if (tgt_w) begin
               w1 <= pay[23:8];
               w2 <= {pay[7:0], rx_data};
            end else begin
               x1 <= pay[23:8];
               x2 <= {pay[7:0], rx_data};
            end
         end
      end
endmodule

// File: tb/tb_perceptron_uart_node.sv
// Scoreboard bench for perceptron_uart_node: a host-side UART
// sends commands, a monitor UART decodes and checks responses.
`timescale 1ns/1ps
module tb_perceptron_uart_node;
   localparam int  CF    = 160000;
   localparam int  BR    = 10000;
   localparam int  TOB   = 16;
   localparam int  BIT   = CF / BR;
   localparam real CLK_P = 10.0;

   typedef logic [7:0] vec_t [7];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;

   int errors = 0;
   int checks = 0;
   int nbytes = 0;

   logic [7:0] exp_q [$];
   logic       mon_en = 1'b1;
   logic       mon_busy = 1'b0;
   logic       first_pending = 1'b0;
   realtime    t_mid = 0;

   perceptron_uart_node #(
      .CLOCK_FREQUENCY(CF),
      .BAUD_RATE(BR),
      .TIMEOUT_BYTES(TOB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tx(tx)
   );

   always #5 clk = ~clk;

   initial begin
      #(60000 * CLK_P);
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   // response monitor
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      logic       sb;
      realtime    dt;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            mon_busy = 1'b1;
            if (first_pending) begin
               first_pending = 1'b0;
               dt = $realtime - t_mid;
               checks++;
               if (dt > 17.0 * CLK_P) begin
                  errors++;
                  $display("FAIL resp_latency got=%0t ns required<=%0t ns",
                           dt, 17.0 * CLK_P);
               end
            end
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            sb = tx;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte got=%0d stop=%b required=none",
                        b, sb);
            end else begin
               e = exp_q.pop_front();
               if (b !== e || sb !== 1'b1) begin
                  errors++;
                  $display("FAIL resp_byte#%0d got=%0d stop=%b required=%0d stop=1",
                           nbytes, b, sb, e);
               end
            end
            nbytes++;
            mon_busy = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         if (i == 9) begin
            repeat (BIT / 2) @(negedge clk);
            t_mid = $realtime;
            repeat (BIT - BIT / 2) @(negedge clk);
         end else begin
            repeat (BIT) @(negedge clk);
         end
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 12 * 10 * BIT) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got=%0d bytes missing required=0",
                  name, exp_q.size());
         exp_q.delete();
      end
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic cmd(input vec_t s, input int ns,
                      input vec_t e, input int ne, input string name);
      for (int i = 0; i < ne; i++) exp_q.push_back(e[i]);
      for (int i = 0; i < ns; i++) begin
         if (i == ns - 1 && ne > 0) first_pending = 1'b1;
         send_byte(s[i]);
      end
      if (ne > 0) wait_done(name);
   endtask

   task automatic do_read(input logic [15:0] w1, input logic [15:0] w2,
                          input logic [15:0] r, input string name);
      vec_t s;
      vec_t e;
      s = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      e = '{8'd100, w1[15:8], w1[7:0], w2[15:8], w2[7:0], r[15:8], r[7:0]};
      cmd(s, 1, e, 7, name);
   endtask

   initial begin
      vec_t z;
      logic seen_low;
      z = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      repeat (4) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx got=%b required=1", tx);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);

      do_read(16'h0000, 16'h0000, 16'h0001, "read_reset");

      cmd('{8'd50, 8'h15, 8'hAA, 8'hFC, 8'h33, 8'd0, 8'd0}, 5,
          '{8'd101, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, "ack_w");
      do_read(16'h15AA, 16'hFC33, 16'h0001, "read_w");

      cmd('{8'd51, 8'hE0, 8'h00, 8'h20, 8'h0F, 8'd0, 8'd0}, 5,
          '{8'd101, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, "ack_x");
      do_read(16'h15AA, 16'hFC33, 16'h0000, "read_x");

      cmd('{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1,
          '{8'd102, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, "err");
      do_read(16'h15AA, 16'hFC33, 16'h0000, "read_err");

      cmd('{8'd50, 8'h01, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2, z, 0, "partial");
      seen_low = 1'b0;
      repeat ((TOB + 1) * 10 * BIT) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
      end
      checks++;
      if (seen_low) begin
         errors++;
         $display("FAIL timeout_silent got=tx_activity required=idle");
      end
      do_read(16'h15AA, 16'hFC33, 16'h0000, "read_timeout");

      mon_en = 1'b0;
      send_byte(8'd5);
      repeat (20) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_tx got=%b required=0", tx);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_tx got=%b required=1", tx);
      end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      mon_en = 1'b1;
      do_read(16'h0000, 16'h0000, 16'h0001, "read_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
